msg_sequencer: RTL and testbench
================================

# msg_sequencer

Parametrised message sequencer: holds a software-loadable byte buffer and streams its first `msg_len` bytes to the UART transmitter over a valid/ready handshake, either once per `start` or periodically with a programmable inter-frame gap. It sits between the board-level control logic (switches/host write port) and the `transmit` UART block. It replaces the fixed-string, fixed-pacing message generator.

## Interface
Parameters:
- `MSG_MAX_LEN`, 32: buffer depth in bytes (≥2).
- `GAP_W`, 16: width of the inter-frame gap counter.
- `LEN_W`, $clog2(MSG_MAX_LEN+1): width of length inputs (derived, not overridden).

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables sequencing; low blocks new frames.
- `mode`  in  1  0 = one-shot, 1 = periodic.
- `start`  in  1  frame request, level-sampled in IDLE.
- `msg_len`  in  LEN_W  payload length in bytes.
- `gap`  in  GAP_W  idle cycles between periodic frames.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  LEN_W  buffer write address.
- `wr_data`  in  8  buffer write byte.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts byte.
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  one-cycle pulse per completed frame.
- `frame_cnt`  out  16  completed-frame counter, wraps.

## Operation
- States: IDLE, SEND, GAP.
- IDLE → SEND when `en && start && msg_len != 0`; `msg_len` (clamped to MSG_MAX_LEN) and `gap` latched; byte index = 0. `msg_len == 0`: start ignored, no `done`.
- SEND: `tx_data` = buffer[index], `tx_valid` = 1. Transfer when `tx_valid && tx_ready` at posedge; index increments. `tx_data` stable while `tx_valid && !tx_ready`.
- After final transfer: `done` pulses, `frame_cnt` += 1. If `mode && en` → GAP (or directly SEND with re-latched `msg_len`/`gap` when gap = 0); else → IDLE.
- GAP: counts latched `gap` cycles with `tx_valid` = 0, then SEND with re-latched `msg_len`/`gap`. `en` falling during GAP → IDLE immediately. `en` falling during SEND: current frame completes, then IDLE.
- `start` while busy ignored. `mode` evaluated only at frame end.
- Writes: `wr_en` honoured only in IDLE; `wr_addr >= MSG_MAX_LEN` ignored.
- Reset: state IDLE, index 0, `tx_valid` 0, `tx_data` 0x00, `busy` 0, `done` 0, `frame_cnt` 0. Buffer contents are not reset and survive `rst`. Reset mid-frame aborts immediately; no `done`.

## Timing
- `start` sampled at edge N → `tx_valid` high with byte 0 from N+1 (`busy` high same cycle).
- Back-to-back transfers with `tx_ready` held high: one byte per cycle.
- `done` high for the single cycle following the last transfer edge.
- Periodic: after last transfer, `tx_valid` low exactly `gap` cycles; gap = 0 keeps `tx_valid` high continuously across frames.
- Buffer write visible to a frame started on the following edge or later.

## Configuration
- `MSG_CHECKSUM_EN` defined: after the last payload byte, SEND emits one extra byte = XOR of all payload bytes of that frame, with the same handshake; `done` follows the checksum transfer. Frame length = `msg_len` + 1.
- Undefined: frame is exactly `msg_len` payload bytes; no checksum logic.

## Structure
- Package `msg_seq_pkg`: state enum (IDLE/SEND/GAP), frame counter width constant (16), checksum seed constant (8'h00).
- Sub-module `msg_buffer`: MSG_MAX_LEN×8 register array, synchronous write port, combinational read by index.

## Test plan
- Load "Hi\n" (0x48,0x69,0x0A), `msg_len`=3, mode 0, `tx_ready`=1, pulse start → bytes 48,69,0A on three consecutive cycles, `done` once, `frame_cnt`=1, back to IDLE.
- Same frame, `tx_ready` toggling 1-of-3 cycles → `tx_data` stable while stalled, order 48,69,0A, no duplicates.
- Mode 1, `gap`=5, `msg_len`=2 → `tx_valid` low exactly 5 cycles between frames; drop `en` mid-frame → frame completes, then IDLE.
- `msg_len`=40 with MSG_MAX_LEN=32 → 32 bytes sent; `msg_len`=0 → no `tx_valid`, no `done`; `wr_en` during SEND → buffer unchanged.
- `rst` low during byte 1 of a 3-byte frame → `tx_valid`=0, `frame_cnt`=0 immediately; next start sends from byte 0; buffer preserved.
- With `MSG_CHECKSUM_EN`, payload 0x48,0x69,0x0A → fourth byte 0x2B, `done` after it.

Source files
------------

// File: rtl/msg_seq_pkg.sv
// Shared types and constants for the message sequencer.
// MSG_CHECKSUM_EN (when defined) appends an XOR checksum byte to every frame.
package msg_seq_pkg;
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   localparam int         FRAME_CNT_W = 16;
   localparam logic [7:0] CSUM_SEED   = 8'h00;
endpackage

// File: rtl/msg_buffer.sv
// Message byte store: synchronous write port, combinational read by index.
// Contents are deliberately not reset so a loaded message survives rst.
module msg_buffer #(
   parameter int MSG_MAX_LEN = 32,
   parameter int LEN_W       = $clog2(MSG_MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [LEN_W-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);
   localparam int AW = $clog2(MSG_MAX_LEN);

   logic [7:0] mem [MSG_MAX_LEN];

   // The range guard keeps truncated out-of-range addresses from aliasing.
   always_ff @(posedge clk) begin
      if (we && (wr_addr < LEN_W'(MSG_MAX_LEN)))
         mem[wr_addr[AW-1:0]] <= wr_data;
   end

   assign rd_data = (rd_addr < LEN_W'(MSG_MAX_LEN)) ? mem[rd_addr[AW-1:0]] : 8'h00;
endmodule

// File: rtl/msg_sequencer.sv
// Streams the first msg_len buffer bytes over valid/ready, one-shot or periodic.
// Optional MSG_CHECKSUM_EN appends an XOR checksum byte after the payload.
module msg_sequencer
   import msg_seq_pkg::*;
#(
   parameter  int MSG_MAX_LEN = 32,
   parameter  int GAP_W       = 16,
   localparam int LEN_W       = $clog2(MSG_MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   mode,
   input  logic                   start,
   input  logic [LEN_W-1:0]       msg_len,
   input  logic [GAP_W-1:0]       gap,
   input  logic                   wr_en,
   input  logic [LEN_W-1:0]       wr_addr,
   input  logic [7:0]             wr_data,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   done,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);
   state_t                 state_q, state_d;
   logic [LEN_W-1:0]       idx_q, idx_d, len_q, len_d;
   logic [GAP_W-1:0]       gap_q, gap_d, gcnt_q, gcnt_d;
   logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
   logic                   done_q, done_d;
   logic [LEN_W-1:0]       len_clamp;
   logic [7:0]             rd_data;
   logic                   xfer, last;

   msg_buffer #(.MSG_MAX_LEN(MSG_MAX_LEN), .LEN_W(LEN_W)) u_buf (
      .clk    (clk),
      .we     (wr_en && (state_q == IDLE)),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(idx_q),
      .rd_data(rd_data)
   );

   assign len_clamp = (msg_len > LEN_W'(MSG_MAX_LEN)) ? LEN_W'(MSG_MAX_LEN) : msg_len;
   assign xfer      = (state_q == SEND) && tx_ready;
   assign tx_valid  = (state_q == SEND);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign frame_cnt = fcnt_q;

`ifdef MSG_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       payload;

   // Index len_q is the slot after the payload, where the checksum goes out.
   assign payload = (idx_q != len_q);
   assign last    = !payload;
   assign tx_data = (state_q == SEND) ? (payload ? rd_data : csum_q) : 8'h00;
`else
   assign last    = (idx_q == len_q - LEN_W'(1));
   assign tx_data = (state_q == SEND) ? rd_data : 8'h00;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         fcnt_q  <= '0;
         done_q  <= 1'b0;
`ifdef MSG_CHECKSUM_EN
         csum_q  <= CSUM_SEED;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         fcnt_q  <= fcnt_d;
         done_q  <= done_d;
`ifdef MSG_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      fcnt_d  = fcnt_q;
      done_d  = 1'b0;
`ifdef MSG_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (en && start && (msg_len != '0)) begin
               state_d = SEND;
               idx_d   = '0;
               len_d   = len_clamp;
               gap_d   = gap;
`ifdef MSG_CHECKSUM_EN
               csum_d  = CSUM_SEED;
`endif
            end
         end
         SEND: begin
            if (xfer) begin
               idx_d = idx_q + LEN_W'(1);
`ifdef MSG_CHECKSUM_EN
               if (payload) csum_d = csum_q ^ rd_data;
`endif
               if (last) begin
                  done_d = 1'b1;
                  fcnt_d = fcnt_q + FRAME_CNT_W'(1);
                  idx_d  = '0;
`ifdef MSG_CHECKSUM_EN
                  csum_d = CSUM_SEED;
`endif
                  if (!(mode && en) || ((gap_q == '0) && (msg_len == '0))) begin
                     state_d = IDLE;
                  end else if (gap_q == '0) begin
                     len_d = len_clamp;
                     gap_d = gap;
                  end else begin
                     state_d = GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end
         end
         GAP: begin
            if (!en || ((gcnt_q == GAP_W'(1)) && (msg_len == '0))) begin
               state_d = IDLE;
            end else if (gcnt_q == GAP_W'(1)) begin
               state_d = SEND;
               idx_d   = '0;
               len_d   = len_clamp;
               gap_d   = gap;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_msg_sequencer.sv
// Directed self-checking bench for msg_sequencer (default 32-byte build).
module tb_msg_sequencer;
   localparam int LEN_W = 6;
   localparam int GAP_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             en, mode, start, wr_en, tx_ready;
   logic [LEN_W-1:0] msg_len, wr_addr;
   logic [GAP_W-1:0] gap;
   logic [7:0]       wr_data, tx_data;
   logic             tx_valid, busy, done;
   logic [15:0]      frame_cnt;

   int passed = 0;
   int total  = 0;

   logic [7:0] got [64];
   int n_got, n_done, stall_err, last_v_c, done_c;

   msg_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
      .msg_len(msg_len), .gap(gap), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int i);
      case (i)
         0: pat = 8'h48;
         1: pat = 8'h69;
         2: pat = 8'h0A;
         default: pat = 8'(i * 7 + 3);
      endcase
   endfunction

   // All tasks are entered and left on a falling edge.
   task automatic write_byte(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = LEN_W'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Records accepted bytes and done pulses; ready is high one cycle in 'period'.
   task automatic collect(input int cycles, input int period);
      logic       stalled;
      logic [7:0] held;
      n_got = 0; n_done = 0; stall_err = 0; last_v_c = -1; done_c = -1;
      stalled = 1'b0; held = 8'h00;
      for (int c = 0; c < cycles; c++) begin
         if (stalled && (tx_valid !== 1'b1 || tx_data !== held)) stall_err++;
         if (done === 1'b1) begin n_done++; done_c = c; end
         tx_ready = ((c % period) == period - 1);
         if (tx_valid === 1'b1 && tx_ready) begin
            if (n_got < 64) got[n_got] = tx_data;
            n_got++;
            last_v_c = c;
         end
         stalled = (tx_valid === 1'b1) && !tx_ready;
         held    = tx_data;
         @(negedge clk);
      end
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; wr_en = 1'b0;
      tx_ready = 1'b1; msg_len = '0; wr_addr = '0; wr_data = 8'h00; gap = '0;
      @(negedge clk); @(negedge clk);
      total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", tx_valid); else passed++;
      total++; if (tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", tx_data); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else passed++;
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) write_byte(i, pat(i));
   endtask

   task automatic test_basic();
      en = 1'b1; mode = 1'b0; msg_len = 6'd3;
      kick();
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) $display("FAIL basic_b0 got v=%b d=%h want v=1 d=48", tx_valid, tx_data); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
      @(negedge clk);
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) $display("FAIL basic_b1 got v=%b d=%h want v=1 d=69", tx_valid, tx_data); else passed++;
      @(negedge clk);
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A) $display("FAIL basic_b2 got v=%b d=%h want v=1 d=0a", tx_valid, tx_data); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b1 || tx_valid !== 1'b0) $display("FAIL basic_done got done=%b v=%b want done=1 v=0", done, tx_valid); else passed++;
      total++; if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL basic_idle got busy=%b want 0", busy); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
   endtask

   task automatic test_stall();
      msg_len = 6'd3;
      kick();
      collect(30, 3);
      total++; if (n_got !== 3) $display("FAIL stall_count got %0d want 3", n_got); else passed++;
      total++; if (got[0] !== 8'h48 || got[1] !== 8'h69 || got[2] !== 8'h0A)
         $display("FAIL stall_order got %h %h %h want 48 69 0a", got[0], got[1], got[2]); else passed++;
      total++; if (stall_err !== 0) $display("FAIL stall_stable got %0d changes want 0", stall_err); else passed++;
      total++; if (n_done !== 1) $display("FAIL stall_done got %0d want 1", n_done); else passed++;
      total++; if (frame_cnt !== 16'd2) $display("FAIL stall_frame_cnt got %0d want 2", frame_cnt); else passed++;
   endtask

   task automatic test_periodic();
      int errs = 0, dn = 0;
      logic [7:0] d15 = 8'h00;
      mode = 1'b1; gap = 16'd5; msg_len = 6'd2;
      kick();
      for (int c = 0; c < 26; c++) begin
         if (tx_valid !== ((c < 16) && ((c % 7) < 2))) errs++;
         if (done === 1'b1) dn++;
         if (c == 15) d15 = tx_data;
         if (c == 14) en = 1'b0;
         @(negedge clk);
      end
      total++; if (errs !== 0) $display("FAIL periodic_valid_pattern got %0d bad cycles want 0", errs); else passed++;
      total++; if (d15 !== 8'h69) $display("FAIL periodic_last_byte got %h want 69", d15); else passed++;
      total++; if (dn !== 3) $display("FAIL periodic_done got %0d want 3", dn); else passed++;
      total++; if (frame_cnt !== 16'd5) $display("FAIL periodic_frame_cnt got %0d want 5", frame_cnt); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL periodic_idle got busy=%b want 0", busy); else passed++;
      en = 1'b1; mode = 1'b0;
   endtask

   task automatic test_gap0();
      int errs = 0;
      mode = 1'b1; gap = 16'd0; msg_len = 6'd2;
      kick();
      for (int c = 0; c < 6; c++) begin
         if (tx_valid !== 1'b1 || tx_data !== ((c % 2 == 0) ? 8'h48 : 8'h69)) errs++;
         if (c == 5) en = 1'b0;
         @(negedge clk);
      end
      total++; if (errs !== 0) $display("FAIL gap0_stream got %0d bad cycles want 0", errs); else passed++;
      total++; if (done !== 1'b1 || tx_valid !== 1'b0) $display("FAIL gap0_end got done=%b v=%b want done=1 v=0", done, tx_valid); else passed++;
      total++; if (frame_cnt !== 16'd8) $display("FAIL gap0_frame_cnt got %0d want 8", frame_cnt); else passed++;
      en = 1'b1; mode = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clamp_len0();
      int errs = 0;
      for (int i = 3; i < 32; i++) write_byte(i, pat(i));
      write_byte(40, 8'hEE);
      msg_len = 6'd40;
      kick();
      collect(40, 1);
      for (int i = 0; i < 32; i++) if (got[i] !== pat(i)) errs++;
      total++; if (n_got !== 32) $display("FAIL clamp_count got %0d want 32", n_got); else passed++;
      total++; if (errs !== 0) $display("FAIL clamp_bytes got %0d wrong want 0", errs); else passed++;
      total++; if (n_done !== 1) $display("FAIL clamp_done got %0d want 1", n_done); else passed++;
      msg_len = 6'd0;
      kick();
      collect(8, 1);
      total++; if (n_got !== 0 || n_done !== 0) $display("FAIL len0 got bytes=%0d done=%0d want 0 0", n_got, n_done); else passed++;
      total++; if (frame_cnt !== 16'd9) $display("FAIL len0_frame_cnt got %0d want 9", frame_cnt); else passed++;
   endtask

   task automatic test_write_block();
      msg_len = 6'd3;
      kick();
      wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'hEE;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      kick();
      collect(6, 1);
      total++; if (n_got !== 3 || got[1] !== 8'h69) $display("FAIL write_block got n=%0d b1=%h want n=3 b1=69", n_got, got[1]); else passed++;
      total++; if (frame_cnt !== 16'd11) $display("FAIL write_block_frame_cnt got %0d want 11", frame_cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      msg_len = 6'd3;
      kick();
      @(negedge clk);
      total++; if (tx_data !== 8'h69) $display("FAIL rstmid_pre got %h want 69", tx_data); else passed++;
      rst = 1'b0;
      #1;
      total++; if (tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_abort got v=%b busy=%b want 0 0", tx_valid, busy); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passed++;
      rst = 1'b1;
      @(negedge clk);
      kick();
      collect(6, 1);
      total++; if (n_got !== 3 || got[0] !== 8'h48 || got[1] !== 8'h69 || got[2] !== 8'h0A)
         $display("FAIL rstmid_restart got n=%0d %h %h %h want 3 48 69 0a", n_got, got[0], got[1], got[2]); else passed++;
      total++; if (n_done !== 1 || frame_cnt !== 16'd1) $display("FAIL rstmid_count got done=%0d cnt=%0d want 1 1", n_done, frame_cnt); else passed++;
   endtask

`ifdef MSG_CHECKSUM_EN
   task automatic test_checksum();
      en = 1'b1; mode = 1'b0; msg_len = 6'd3;
      kick();
      collect(10, 1);
      total++; if (n_got !== 4) $display("FAIL csum_count got %0d want 4", n_got); else passed++;
      total++; if (got[3] !== 8'h2B) $display("FAIL csum_byte got %h want 2b", got[3]); else passed++;
      total++; if (n_done !== 1 || done_c !== last_v_c + 1) $display("FAIL csum_done got n=%0d at %0d want 1 at %0d", n_done, done_c, last_v_c + 1); else passed++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef MSG_CHECKSUM_EN
      test_checksum();
`else
      test_basic();
      test_stall();
      test_periodic();
      test_gap0();
      test_clamp_len0();
      test_write_block();
      test_reset_mid();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
